// File: rtl/waypoint_sequencer_if.sv
// -----------------------------------------------------------------------------
// waypoint_sequencer_if
// Purpose : groups the control, manual-duty and duty/status signals of the
//           waypoint sequencer into one bundle.
// Signals : Rec      - one-cycle pulse, store current manual duty as waypoint
//           Clear    - one-cycle pulse, empty the waypoint list
//           Play_En  - level, high = loop playback, low = manual pass-through
//           Cur_X/Y  - live manual duty values
//           DC_X/Y   - registered duty to the PWM comparators
//           Count    - number of stored waypoints
//           Full     - Count equals DEPTH
//           Playing  - sequencer is in a playback state
//           At_Point - one-cycle pulse on waypoint arrival
// Modports: master drives the controls and reads status (user / testbench),
//           slave is the sequencer itself.
// -----------------------------------------------------------------------------
interface waypoint_sequencer_if #(
  parameter int W     = 6,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          Rec;
  logic          Clear;
  logic          Play_En;
  logic [W-1:0]  Cur_X;
  logic [W-1:0]  Cur_Y;
  logic [W-1:0]  DC_X;
  logic [W-1:0]  DC_Y;
  logic [CW-1:0] Count;
  logic          Full;
  logic          Playing;
  logic          At_Point;

  modport master (
    output Rec, Clear, Play_En, Cur_X, Cur_Y,
    input  DC_X, DC_Y, Count, Full, Playing, At_Point
  );

  modport slave (
    input  Rec, Clear, Play_En, Cur_X, Cur_Y,
    output DC_X, DC_Y, Count, Full, Playing, At_Point
  );
endinterface

// File: rtl/waypoint_sequencer.sv
// -----------------------------------------------------------------------------
// waypoint_sequencer
// Purpose : records up to DEPTH (X,Y) duty waypoints and, when playback is
//           enabled, loops through them, slewing each duty axis 1 LSB every
//           STEP_DIV cycles and dwelling DWELL cycles at each waypoint. With
//           playback off the duty outputs track the manual inputs.
// Ports   : sysclk   - sole clock, rising edge
//           Reset_Sw - asynchronous active-low reset
//           bus      - waypoint_sequencer_if.slave (controls, duty, status)
// -----------------------------------------------------------------------------
module waypoint_sequencer #(
  parameter int W        = 6,
  parameter int DEPTH    = 8,
  parameter int STEP_DIV = 16,
  parameter int DWELL    = 64
) (
  input  logic                  sysclk,
  input  logic                  Reset_Sw,
  waypoint_sequencer_if.slave   bus
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int DWW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SLEW,
    ST_DWELL
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  dc_x_q, dc_x_d;
  logic [W-1:0]  dc_y_q, dc_y_d;
  logic [W-1:0]  tgt_x_q, tgt_x_d;
  logic [W-1:0]  tgt_y_q, tgt_y_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] index_q, index_d;
  logic [SW-1:0] step_q, step_d;
  logic [DWW-1:0] dwell_q, dwell_d;
  logic          at_point_q, at_point_d;
  logic          wr_en;
  logic          full;
  logic          last_index;

  logic [W-1:0]  slot_x [DEPTH];
  logic [W-1:0]  slot_y [DEPTH];

  // Moves one axis a single LSB toward its target; an equal axis stays put,
  // so the value can never overshoot or wrap.
  function automatic logic [W-1:0] step_toward(input logic [W-1:0] cur,
                                               input logic [W-1:0] tgt);
    if (cur < tgt) begin
      return cur + W'(1);
    end else if (cur > tgt) begin
      return cur - W'(1);
    end else begin
      return cur;
    end
  endfunction

  assign full       = (count_q == CW'(DEPTH));
  assign last_index = ((CW'(index_q) + CW'(1)) == count_q);

  // Next-state and datapath. Abort (Play_En low) and Clear are applied last
  // so they override whatever the current state computed.
  always_comb begin
    state_d    = state_q;
    dc_x_d     = dc_x_q;
    dc_y_d     = dc_y_q;
    tgt_x_d    = tgt_x_q;
    tgt_y_d    = tgt_y_q;
    count_d    = count_q;
    index_d    = index_q;
    step_d     = step_q;
    dwell_d    = dwell_q;
    at_point_d = 1'b0;
    wr_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        dc_x_d  = bus.Cur_X;
        dc_y_d  = bus.Cur_Y;
        index_d = '0;
        step_d  = '0;
        dwell_d = '0;
        if (bus.Rec && !full) begin
          wr_en   = 1'b1;
          count_d = count_q + CW'(1);
        end
        if (bus.Play_En && (count_q != '0)) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        tgt_x_d = slot_x[index_q];
        tgt_y_d = slot_y[index_q];
        step_d  = '0;
        state_d = ST_SLEW;
      end

      ST_SLEW: begin
        if ((dc_x_q == tgt_x_q) && (dc_y_q == tgt_y_q)) begin
          state_d    = ST_DWELL;
          at_point_d = 1'b1;
          dwell_d    = '0;
        end else if (step_q == SW'(STEP_DIV - 1)) begin
          step_d = '0;
          dc_x_d = step_toward(dc_x_q, tgt_x_q);
          dc_y_d = step_toward(dc_y_q, tgt_y_q);
        end else begin
          step_d = step_q + SW'(1);
        end
      end

      ST_DWELL: begin
        if (dwell_q == DWW'(DWELL - 1)) begin
          dwell_d = '0;
          index_d = last_index ? '0 : index_q + IW'(1);
          state_d = ST_LOAD;
        end else begin
          dwell_d = dwell_q + DWW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Leaving playback holds the duty for one cycle; IDLE then resumes
    // tracking the manual inputs.
    if ((state_q != ST_IDLE) && !bus.Play_En) begin
      state_d    = ST_IDLE;
      dc_x_d     = dc_x_q;
      dc_y_d     = dc_y_q;
      index_d    = '0;
      step_d     = '0;
      dwell_d    = '0;
      at_point_d = 1'b0;
    end

    // Clear beats a simultaneous Rec; slot contents become unreachable.
    if (bus.Clear) begin
      state_d    = ST_IDLE;
      count_d    = '0;
      wr_en      = 1'b0;
      index_d    = '0;
      step_d     = '0;
      dwell_d    = '0;
      at_point_d = 1'b0;
    end
  end

  // Control and duty registers.
  always_ff @(posedge sysclk or negedge Reset_Sw) begin
    if (!Reset_Sw) begin
      state_q    <= ST_IDLE;
      dc_x_q     <= '0;
      dc_y_q     <= '0;
      tgt_x_q    <= '0;
      tgt_y_q    <= '0;
      count_q    <= '0;
      index_q    <= '0;
      step_q     <= '0;
      dwell_q    <= '0;
      at_point_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dc_x_q     <= dc_x_d;
      dc_y_q     <= dc_y_d;
      tgt_x_q    <= tgt_x_d;
      tgt_y_q    <= tgt_y_d;
      count_q    <= count_d;
      index_q    <= index_d;
      step_q     <= step_d;
      dwell_q    <= dwell_d;
      at_point_q <= at_point_d;
    end
  end

  // Waypoint storage is deliberately not reset; Count gates every access.
  always_ff @(posedge sysclk) begin
    if (wr_en) begin
      slot_x[count_q[IW-1:0]] <= bus.Cur_X;
      slot_y[count_q[IW-1:0]] <= bus.Cur_Y;
    end
  end

  assign bus.DC_X     = dc_x_q;
  assign bus.DC_Y     = dc_y_q;
  assign bus.Count    = count_q;
  assign bus.Full     = full;
  assign bus.Playing  = (state_q != ST_IDLE);
  assign bus.At_Point = at_point_q;

endmodule

// File: tb/tb_waypoint_sequencer.sv
// -----------------------------------------------------------------------------
// tb_waypoint_sequencer
// Purpose : directed self-checking bench for waypoint_sequencer with
//           W=6, DEPTH=4, STEP_DIV=2, DWELL=3. Expected values are queued on
//           a scoreboard as stimulus is applied and popped when the DUT output
//           is sampled (1 time unit after the rising edge).
// -----------------------------------------------------------------------------
module tb_waypoint_sequencer;

  localparam int W        = 6;
  localparam int DEPTH    = 4;
  localparam int STEP_DIV = 2;
  localparam int DWELL    = 3;

  logic sysclk = 1'b0;
  logic Reset_Sw;

  always #5 sysclk = ~sysclk;

  waypoint_sequencer_if #(.W(W), .DEPTH(DEPTH)) bus ();

  waypoint_sequencer #(
    .W(W), .DEPTH(DEPTH), .STEP_DIV(STEP_DIV), .DWELL(DWELL)
  ) dut (
    .sysclk  (sysclk),
    .Reset_Sw(Reset_Sw),
    .bus     (bus)
  );

  typedef struct {
    string       tag;
    logic [15:0] value;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Advance n clocks and land 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic rec, input logic clear,
                                input logic play, input logic [W-1:0] x,
                                input logic [W-1:0] y);
    bus.Rec     = rec;
    bus.Clear   = clear;
    bus.Play_En = play;
    bus.Cur_X   = x;
    bus.Cur_Y   = y;
  endtask

  task automatic push_expect(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag   = tag;
    e.value = v;
    sb_q.push_back(e);
  endtask

  task automatic check_output(input logic [15:0] obs);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("[TB] FAIL unexpected_output observed=%0h expected=none", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.value) else begin
        failures++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.value);
      end
    end
  endtask

  // Any expectation still queued means the DUT never produced that output.
  task automatic drain_timeout();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      failures++;
      $error("[TB] FAIL %s observed=timeout expected=%0h", e.tag, e.value);
    end
  endtask

  function automatic logic [15:0] pair(input logic [W-1:0] x,
                                       input logic [W-1:0] y);
    return {4'b0, x, y};
  endfunction

  function automatic logic [15:0] flags(input logic [2:0] c, input logic f,
                                        input logic p, input logic a);
    return {10'b0, c, f, p, a};
  endfunction

  function automatic logic [15:0] dc_obs();
    return {4'b0, bus.DC_X, bus.DC_Y};
  endfunction

  function automatic logic [15:0] flag_obs();
    return {10'b0, bus.Count, bus.Full, bus.Playing, bus.At_Point};
  endfunction

  initial begin
    // Reset with manual duty present: outputs forced to zero.
    Reset_Sw = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 6'd10, 6'd20);
    #2 Reset_Sw = 1'b0;
    tick(2);
    push_expect("reset_dc", pair(6'd0, 6'd0));
    check_output(dc_obs());
    push_expect("reset_flags", flags(3'd0, 1'b0, 1'b0, 1'b0));
    check_output(flag_obs());
    Reset_Sw = 1'b1;
    tick(1);
    push_expect("release_dc", pair(6'd10, 6'd20));
    check_output(dc_obs());

    // Fill the list: fifth Rec ignored once Full.
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0, 6'(i + 1), 6'(i + 2));
      push_expect("rec_count", flags(3'((i < 4) ? i + 1 : 4), (i >= 3), 1'b0, 1'b0));
      tick(1);
      check_output(flag_obs());
    end
    apply_stimulus(1'b1, 1'b1, 1'b0, 6'd1, 6'd1);
    push_expect("rec_clear_same_cycle", flags(3'd0, 1'b0, 1'b0, 1'b0));
    tick(1);
    check_output(flag_obs());

    // Play_En with an empty list stays in pass-through.
    apply_stimulus(1'b0, 1'b0, 1'b1, 6'd33, 6'd44);
    tick(1);
    push_expect("empty_play_flags", flags(3'd0, 1'b0, 1'b0, 1'b0));
    check_output(flag_obs());
    push_expect("empty_play_dc", pair(6'd33, 6'd44));
    check_output(dc_obs());
    apply_stimulus(1'b0, 1'b0, 1'b1, 6'd34, 6'd45);
    tick(1);
    push_expect("empty_play_track", pair(6'd34, 6'd45));
    check_output(dc_obs());

    // Record (5,5) and (9,1), then play from DC=(7,3).
    apply_stimulus(1'b1, 1'b0, 1'b0, 6'd5, 6'd5);
    tick(1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 6'd9, 6'd1);
    tick(1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 6'd7, 6'd3);
    tick(1);
    push_expect("pre_play_dc", pair(6'd7, 6'd3));
    check_output(dc_obs());
    apply_stimulus(1'b0, 1'b0, 1'b1, 6'd7, 6'd3);
    push_expect("slew_c1", pair(6'd7, 6'd3));
    push_expect("slew_c2", pair(6'd7, 6'd3));
    push_expect("slew_c3", pair(6'd7, 6'd3));
    push_expect("slew_c4", pair(6'd6, 6'd4));
    push_expect("slew_c5", pair(6'd6, 6'd4));
    push_expect("slew_c6", pair(6'd5, 6'd5));
    push_expect("slew_c7", pair(6'd5, 6'd5));
    for (int c = 1; c <= 7; c++) begin
      tick(1);
      check_output(dc_obs());
    end
    push_expect("arrive1_flags", flags(3'd2, 1'b0, 1'b1, 1'b1));
    check_output(flag_obs());
    push_expect("arrive2_cycle", 16'd20);
    push_expect("arrive2_dc", pair(6'd9, 6'd1));
    push_expect("arrive3_cycle", 16'd33);
    push_expect("arrive3_dc", pair(6'd5, 6'd5));
    for (int c = 8; c <= 40; c++) begin
      tick(1);
      if (bus.At_Point) begin
        check_output(16'(c));
        check_output(dc_obs());
      end
    end
    drain_timeout();

    // Leave playback, re-seed DC, then abort mid-SLEW.
    apply_stimulus(1'b0, 1'b0, 1'b0, 6'd20, 6'd20);
    tick(2);
    push_expect("manual_reseed", pair(6'd20, 6'd20));
    check_output(dc_obs());
    apply_stimulus(1'b0, 1'b0, 1'b1, 6'd20, 6'd20);
    tick(4);
    push_expect("mid_slew_dc", pair(6'd19, 6'd19));
    check_output(dc_obs());
    apply_stimulus(1'b1, 1'b0, 1'b1, 6'd40, 6'd41);
    tick(1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 6'd40, 6'd41);
    push_expect("rec_in_slew_ignored", flags(3'd2, 1'b0, 1'b1, 1'b0));
    check_output(flag_obs());
    apply_stimulus(1'b0, 1'b0, 1'b0, 6'd40, 6'd41);
    tick(1);
    push_expect("abort_flags", flags(3'd2, 1'b0, 1'b0, 1'b0));
    check_output(flag_obs());
    push_expect("abort_dc_held", pair(6'd19, 6'd19));
    check_output(dc_obs());
    tick(1);
    push_expect("abort_dc_tracks", pair(6'd40, 6'd41));
    check_output(dc_obs());

    // Reach DWELL, then assert reset between clock edges.
    apply_stimulus(1'b0, 1'b0, 1'b0, 6'd5, 6'd5);
    tick(1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 6'd5, 6'd5);
    tick(3);
    push_expect("dwell_arrive_flags", flags(3'd2, 1'b0, 1'b1, 1'b1));
    check_output(flag_obs());
    tick(1);
    push_expect("dwell_mid_flags", flags(3'd2, 1'b0, 1'b1, 1'b0));
    check_output(flag_obs());
    #2 Reset_Sw = 1'b0;
    #1;
    push_expect("async_reset_dc", pair(6'd0, 6'd0));
    check_output(dc_obs());
    push_expect("async_reset_flags", flags(3'd0, 1'b0, 1'b0, 1'b0));
    check_output(flag_obs());
    tick(2);
    Reset_Sw = 1'b1;
    tick(2);
    push_expect("post_reset_flags", flags(3'd0, 1'b0, 1'b0, 1'b0));
    check_output(flag_obs());
    push_expect("post_reset_dc", pair(6'd5, 6'd5));
    check_output(dc_obs());

    // Single waypoint loops on slot 0; Clear mid-playback returns to IDLE.
    apply_stimulus(1'b1, 1'b0, 1'b1, 6'd3, 6'd3);
    tick(1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 6'd3, 6'd3);
    push_expect("single_rec_flags", flags(3'd1, 1'b0, 1'b0, 1'b0));
    check_output(flag_obs());
    tick(1);
    push_expect("single_load_flags", flags(3'd1, 1'b0, 1'b1, 1'b0));
    check_output(flag_obs());
    tick(2);
    push_expect("single_arrive1", flags(3'd1, 1'b0, 1'b1, 1'b1));
    check_output(flag_obs());
    tick(5);
    push_expect("single_arrive2", flags(3'd1, 1'b0, 1'b1, 1'b1));
    check_output(flag_obs());
    push_expect("single_arrive2_dc", pair(6'd3, 6'd3));
    check_output(dc_obs());
    apply_stimulus(1'b0, 1'b1, 1'b1, 6'd3, 6'd3);
    tick(1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 6'd3, 6'd3);
    push_expect("clear_in_play", flags(3'd0, 1'b0, 1'b0, 1'b0));
    check_output(flag_obs());
    tick(1);
    push_expect("clear_stays_idle", flags(3'd0, 1'b0, 1'b0, 1'b0));
    check_output(flag_obs());

    drain_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
